// File: rtl/lcm_report_rx_pkg.sv
// Shared definitions for the LCM statistics report receiver: flit header codes,
// report field offsets and default packet identification values.
package lcm_report_rx_pkg;

    localparam int FLIT_W = 134;

    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_MID   = 2'b11;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    localparam logic [15:0] RPT_ETYPE_DEF = 16'h1662;
    localparam logic [7:0]  RPT_MTYPE_DEF = 8'h02;
    localparam int          RPT_FLITS_DEF = 7;

    // Field offsets inside the 128-bit flit payload
    localparam int ETYPE_LSB = 16;
    localparam int MTYPE_LSB = 8;
    localparam int SEQ_LSB   = 0;
    localparam int SSM_LSB   = 96;
    localparam int TS_LSB    = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_WAIT_VLD,
        ST_DROP
    } rx_state_e;

    // Flits carry counter 1 in the top word; outputs carry counter 1 in the bottom word.
    function automatic logic [127:0] word_order(input logic [127:0] p);
        return {p[31:0], p[63:32], p[95:64], p[127:96]};
    endfunction

endpackage

// File: rtl/lcm_report_rx_if.sv
// Report stream from the NIC: flit bus plus the per-packet valid word.
interface lcm_report_rx_if;
    import lcm_report_rx_pkg::*;

    logic [FLIT_W-1:0] in_rpt_data;
    logic              in_rpt_data_wr;
    logic              in_rpt_valid;
    logic              in_rpt_valid_wr;

    modport master (
        output in_rpt_data,
        output in_rpt_data_wr,
        output in_rpt_valid,
        output in_rpt_valid_wr
    );

    modport slave (
        input in_rpt_data,
        input in_rpt_data_wr,
        input in_rpt_valid,
        input in_rpt_valid_wr
    );

endinterface

// File: rtl/lcm_report_rx.sv
// Host-side LCM report receiver: parses 7-flit reports into shadow registers and
// commits them atomically to the status outputs when the packet is good.
//
// state       | meaning
// ST_IDLE     | waiting for a first flit
// ST_HDR      | first flit seen, expecting the etype/mtype/seq flit
// ST_BODY     | storing counter flits by index until the last flit
// ST_WAIT_VLD | well-formed packet stored, waiting for the valid word
// ST_DROP     | rejected packet, swallowing flits until its valid word
module lcm_report_rx
    import lcm_report_rx_pkg::*;
#(
    parameter logic [15:0] RPT_ETYPE = RPT_ETYPE_DEF,
    parameter logic [7:0]  RPT_MTYPE = RPT_MTYPE_DEF,
    parameter int          RPT_FLITS = RPT_FLITS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    lcm_report_rx_if.slave rpt,
    output logic [255:0]   out_pgm_cnt,
    output logic [255:0]   out_fsm_cnt,
    output logic [31:0]    out_ssm_cnt,
    output logic [47:0]    out_timestamp,
    output logic [7:0]     out_rpt_seq,
    output logic           out_rpt_update,
    output logic           out_rpt_err,
    output logic [15:0]    out_err_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(RPT_FLITS - 1);

    rx_state_e state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic       shd_wr, seq_wr, commit, commit_last, err;

    logic [255:0] shd_pgm, shd_fsm;
    logic [31:0]  shd_ssm;
    logic [47:0]  shd_ts;
    logic [7:0]   shd_seq;

    logic [1:0] flit_hdr;
    logic [3:0] flit_inv;
    logic       id_ok;

    assign flit_hdr = rpt.in_rpt_data[133:132];
    assign flit_inv = rpt.in_rpt_data[131:128];
    assign id_ok    = (rpt.in_rpt_data[ETYPE_LSB +: 16] == RPT_ETYPE) &&
                      (rpt.in_rpt_data[MTYPE_LSB +: 8] == RPT_MTYPE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        shd_wr      = 1'b0;
        seq_wr      = 1'b0;
        commit      = 1'b0;
        commit_last = 1'b0;
        err         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rpt.in_rpt_data_wr) begin
                    if (flit_hdr == HDR_FIRST) begin
                        state_nxt = ST_HDR;
                        idx_nxt   = 3'd1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (rpt.in_rpt_data_wr) begin
                    if (flit_hdr == HDR_MID && id_ok) begin
                        seq_wr    = 1'b1;
                        state_nxt = ST_BODY;
                        idx_nxt   = 3'd2;
                    end else begin
                        err       = 1'b1;
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_BODY: begin
                if (rpt.in_rpt_data_wr) begin
                    case (flit_hdr)
                        HDR_FIRST: begin
                            err       = 1'b1;
                            state_nxt = ST_HDR;
                            idx_nxt   = 3'd1;
                        end
                        HDR_LAST: begin
                            if (idx == LAST_IDX && flit_inv == 4'd0) begin
                                shd_wr = 1'b1;
                                if (rpt.in_rpt_valid_wr) begin
                                    state_nxt   = ST_IDLE;
                                    commit      = rpt.in_rpt_valid;
                                    commit_last = rpt.in_rpt_valid;
                                    err         = !rpt.in_rpt_valid;
                                end else begin
                                    state_nxt = ST_WAIT_VLD;
                                end
                            end else begin
                                // A coincident valid word closes the rejected packet here.
                                err       = 1'b1;
                                state_nxt = rpt.in_rpt_valid_wr ? ST_IDLE : ST_DROP;
                            end
                        end
                        HDR_MID: begin
                            if (idx == LAST_IDX) begin
                                err       = 1'b1;
                                state_nxt = ST_DROP;
                            end else begin
                                shd_wr  = 1'b1;
                                idx_nxt = idx + 3'd1;
                            end
                        end
                        default: begin
                            err       = 1'b1;
                            state_nxt = ST_DROP;
                        end
                    endcase
                end
            end
            ST_WAIT_VLD: begin
                if (rpt.in_rpt_valid_wr) begin
                    commit    = rpt.in_rpt_valid;
                    err       = !rpt.in_rpt_valid;
                    state_nxt = (rpt.in_rpt_data_wr && flit_hdr == HDR_FIRST) ? ST_HDR : ST_IDLE;
                    idx_nxt   = 3'd1;
                end else if (rpt.in_rpt_data_wr && flit_hdr == HDR_FIRST) begin
                    err       = 1'b1;
                    state_nxt = ST_HDR;
                    idx_nxt   = 3'd1;
                end
            end
            ST_DROP: begin
                if (rpt.in_rpt_data_wr && flit_hdr == HDR_FIRST) begin
                    state_nxt = ST_HDR;
                    idx_nxt   = 3'd1;
                end else if (rpt.in_rpt_valid_wr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_pgm <= '0;
            shd_fsm <= '0;
            shd_ssm <= '0;
            shd_ts  <= '0;
            shd_seq <= '0;
        end else begin
            if (seq_wr) shd_seq <= rpt.in_rpt_data[SEQ_LSB +: 8];
            if (shd_wr) begin
                case (idx)
                    3'd2: shd_pgm[127:0]   <= word_order(rpt.in_rpt_data[127:0]);
                    3'd3: shd_pgm[255:128] <= word_order(rpt.in_rpt_data[127:0]);
                    3'd4: shd_fsm[127:0]   <= word_order(rpt.in_rpt_data[127:0]);
                    3'd5: shd_fsm[255:128] <= word_order(rpt.in_rpt_data[127:0]);
                    3'd6: begin
                        shd_ssm <= rpt.in_rpt_data[SSM_LSB +: 32];
                        shd_ts  <= rpt.in_rpt_data[TS_LSB +: 48];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Last-flit commits take ssm/timestamp straight from the bus, the shadow is not loaded yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pgm_cnt    <= '0;
            out_fsm_cnt    <= '0;
            out_ssm_cnt    <= '0;
            out_timestamp  <= '0;
            out_rpt_seq    <= '0;
            out_rpt_update <= 1'b0;
            out_rpt_err    <= 1'b0;
            out_err_cnt    <= '0;
        end else begin
            out_rpt_update <= commit;
            out_rpt_err    <= err;
            if (commit) begin
                out_pgm_cnt   <= shd_pgm;
                out_fsm_cnt   <= shd_fsm;
                out_ssm_cnt   <= commit_last ? rpt.in_rpt_data[SSM_LSB +: 32] : shd_ssm;
                out_timestamp <= commit_last ? rpt.in_rpt_data[TS_LSB +: 48] : shd_ts;
                out_rpt_seq   <= shd_seq;
            end
            if (err && out_err_cnt != 16'hFFFF) out_err_cnt <= out_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lcm_report_rx.sv
// Scoreboard bench for lcm_report_rx: directed report packets push expected
// commit/error events; a negedge monitor pops and compares them.
module tb_lcm_report_rx;

    typedef struct packed {
        logic [255:0] pgm;
        logic [255:0] fsm;
        logic [31:0]  ssm;
        logic [47:0]  ts;
        logic [7:0]   seq;
        logic [15:0]  etype;
        logic [7:0]   mtype;
    } rpt_t;

    typedef struct packed {
        logic         upd;
        logic [255:0] pgm;
        logic [255:0] fsm;
        logic [31:0]  ssm;
        logic [47:0]  ts;
        logic [7:0]   seq;
        logic [15:0]  ecnt;
        logic [31:0]  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcm_report_rx_if rpt_if ();

    logic [255:0] out_pgm_cnt, out_fsm_cnt;
    logic [31:0]  out_ssm_cnt;
    logic [47:0]  out_timestamp;
    logic [7:0]   out_rpt_seq;
    logic         out_rpt_update, out_rpt_err;
    logic [15:0]  out_err_cnt;

    lcm_report_rx dut (
        .clk            (clk),
        .rst            (rst),
        .rpt            (rpt_if.slave),
        .out_pgm_cnt    (out_pgm_cnt),
        .out_fsm_cnt    (out_fsm_cnt),
        .out_ssm_cnt    (out_ssm_cnt),
        .out_timestamp  (out_timestamp),
        .out_rpt_seq    (out_rpt_seq),
        .out_rpt_update (out_rpt_update),
        .out_rpt_err    (out_rpt_err),
        .out_err_cnt    (out_err_cnt)
    );

    int unsigned  errors = 0;
    int unsigned  checks = 0;
    logic [31:0]  cyc = 0;
    exp_t         exp_q[$];

    logic [255:0] m_pgm, m_fsm;
    logic [31:0]  m_ssm;
    logic [47:0]  m_ts;
    logic [7:0]   m_seq;
    logic [15:0]  m_ecnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (out_rpt_update || out_rpt_err)) begin
            exp_t e;
            chk("update_err_exclusive", {255'd0, out_rpt_update & out_rpt_err}, 256'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: update=%0b err=%0b at cycle %0d", out_rpt_update, out_rpt_err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", {255'd0, out_rpt_update}, {255'd0, e.upd});
                chk("event_cycle", {224'd0, cyc}, {224'd0, e.cyc});
                chk("err_cnt", {240'd0, out_err_cnt}, {240'd0, e.ecnt});
                chk("pgm_cnt", out_pgm_cnt, e.pgm);
                chk("fsm_cnt", out_fsm_cnt, e.fsm);
                chk("ssm_cnt", {224'd0, out_ssm_cnt}, {224'd0, e.ssm});
                chk("timestamp", {208'd0, out_timestamp}, {208'd0, e.ts});
                chk("rpt_seq", {248'd0, out_rpt_seq}, {248'd0, e.seq});
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] hdr_of(input int idx);
        if (idx == 0) return 2'b01;
        if (idx == 6) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [127:0] pld_of(input rpt_t r, input int idx);
        logic [127:0] p;
        p = '0;
        case (idx)
            0: p = 128'hC0FFEE00_DEADBEEF_01234567_89ABCDEF;
            1: p[31:0] = {r.etype, r.mtype, r.seq};
            2: p = {r.pgm[31:0], r.pgm[63:32], r.pgm[95:64], r.pgm[127:96]};
            3: p = {r.pgm[159:128], r.pgm[191:160], r.pgm[223:192], r.pgm[255:224]};
            4: p = {r.fsm[31:0], r.fsm[63:32], r.fsm[95:64], r.fsm[127:96]};
            5: p = {r.fsm[159:128], r.fsm[191:160], r.fsm[223:192], r.fsm[255:224]};
            6: begin
                p[127:96] = r.ssm;
                p[95:48]  = r.ts;
                p[47:0]   = 48'hA5A5_5A5A_0F0F;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic rpt_t mk(input logic [7:0] seq, input logic [31:0] base);
        rpt_t r;
        for (int k = 0; k < 8; k++) begin
            r.pgm[32*k +: 32] = base + 32'(k) + 32'h100;
            r.fsm[32*k +: 32] = base + 32'(k) + 32'h200;
        end
        r.ssm   = base + 32'h7;
        r.ts    = {16'hBEEF, base};
        r.seq   = seq;
        r.etype = 16'h1662;
        r.mtype = 8'h02;
        return r;
    endfunction

    task automatic put(input logic [1:0] h, input logic [3:0] inv, input logic [127:0] p,
                       input logic dwr, input logic vwr, input logic v);
        rpt_if.in_rpt_data     = {h, inv, p};
        rpt_if.in_rpt_data_wr  = dwr;
        rpt_if.in_rpt_valid_wr = vwr;
        rpt_if.in_rpt_valid    = v;
        @(negedge clk);
        rpt_if.in_rpt_data_wr  = 1'b0;
        rpt_if.in_rpt_valid_wr = 1'b0;
    endtask

    task automatic flits(input rpt_t r, input int a, input int b);
        for (int i = a; i <= b; i++) put(hdr_of(i), 4'd0, pld_of(r, i), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic vword(input logic v);
        put(2'b00, 4'd0, 128'd0, 1'b0, 1'b1, v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_commit(input rpt_t r);
        m_pgm = r.pgm;
        m_fsm = r.fsm;
        m_ssm = r.ssm;
        m_ts  = r.ts;
        m_seq = r.seq;
        exp_q.push_back('{1'b1, m_pgm, m_fsm, m_ssm, m_ts, m_seq, m_ecnt, cyc + 1});
    endtask

    task automatic exp_err();
        if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
        exp_q.push_back('{1'b0, m_pgm, m_fsm, m_ssm, m_ts, m_seq, m_ecnt, cyc + 1});
    endtask

    task automatic model_reset();
        m_pgm = '0; m_fsm = '0; m_ssm = '0; m_ts = '0; m_seq = '0; m_ecnt = '0;
    endtask

    initial begin
        rpt_t r1, r2, r3, r4, r5, r6, r7, r8, r9;
        int   n;
        rpt_if.in_rpt_data     = '0;
        rpt_if.in_rpt_data_wr  = 1'b0;
        rpt_if.in_rpt_valid    = 1'b0;
        rpt_if.in_rpt_valid_wr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("reset_pgm", out_pgm_cnt, 256'd0);
        chk("reset_err_cnt", {240'd0, out_err_cnt}, 256'd0);
        chk("reset_seq", {248'd0, out_rpt_seq}, 256'd0);

        // 1: good report
        r1 = '0;
        r1.pgm[31:0]    = 32'h11;
        r1.pgm[63:32]   = 32'h22;
        r1.pgm[159:128] = 32'h55;
        r1.fsm[31:0]    = 32'hF1;
        r1.fsm[255:224] = 32'hAB;
        r1.ssm = 32'd5; r1.ts = 48'h1234; r1.seq = 8'd3;
        r1.etype = 16'h1662; r1.mtype = 8'h02;
        flits(r1, 0, 6);
        idle(2);
        exp_commit(r1);
        vword(1'b1);
        idle(2);
        chk("t1_pgm_cnt1", {224'd0, out_pgm_cnt[31:0]}, 256'h11);
        chk("t1_fsm_cnt8", {224'd0, out_fsm_cnt[255:224]}, 256'hAB);
        chk("t1_err_cnt", {240'd0, out_err_cnt}, 256'd0);

        // 2: same packet, valid word bad
        flits(r1, 0, 6);
        exp_err();
        vword(1'b0);
        idle(2);
        chk("t2_err_cnt", {240'd0, out_err_cnt}, 256'd1);

        // 3: wrong ethertype, then a good packet
        r2 = mk(8'd4, 32'h3000);
        r2.etype = 16'h0800;
        flits(r2, 0, 0);
        exp_err();
        flits(r2, 1, 6);
        vword(1'b1);
        r3 = mk(8'd5, 32'h4000);
        flits(r3, 0, 6);
        exp_commit(r3);
        vword(1'b1);
        idle(2);

        // 4: last flit at index 4, valid word afterwards raises no second error
        r4 = mk(8'd6, 32'h5000);
        flits(r4, 0, 3);
        exp_err();
        put(2'b10, 4'd0, pld_of(r4, 4), 1'b1, 1'b0, 1'b0);
        vword(1'b1);
        idle(3);
        chk("t4_err_cnt", {240'd0, out_err_cnt}, 256'd3);
        flits(r4, 0, 6);
        exp_commit(r4);
        vword(1'b1);
        idle(2);

        // 5: new first flit at index 3 restarts the parse
        r5 = mk(8'd7, 32'h6000);
        flits(r4, 0, 2);
        exp_err();
        flits(r5, 0, 0);
        flits(r5, 1, 6);
        exp_commit(r5);
        vword(1'b1);
        idle(2);

        // nonzero invalid-bytes on the last flit, with a coincident valid word
        r6 = mk(8'd8, 32'h7000);
        flits(r6, 0, 5);
        exp_err();
        put(2'b10, 4'h3, pld_of(r6, 6), 1'b1, 1'b1, 1'b1);
        idle(2);

        // new first flit while waiting for the valid word
        r7 = mk(8'd9, 32'h8000);
        flits(r6, 0, 6);
        exp_err();
        flits(r7, 0, 0);
        flits(r7, 1, 6);
        exp_commit(r7);
        vword(1'b1);
        idle(2);

        // 8: valid word coincident with the last flit
        r8 = mk(8'd10, 32'h9000);
        flits(r8, 0, 5);
        exp_commit(r8);
        put(2'b10, 4'd0, pld_of(r8, 6), 1'b1, 1'b1, 1'b1);
        idle(2);

        // 6: reset mid-body, then a good packet
        flits(mk(8'd11, 32'hA000), 0, 3);
        rst = 1'b1;
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("t6_pgm_zero", out_pgm_cnt, 256'd0);
        chk("t6_err_cnt", {240'd0, out_err_cnt}, 256'd0);
        r9 = mk(8'd12, 32'hB000);
        flits(r9, 0, 6);
        chk("t6_pre_commit_ssm", {224'd0, out_ssm_cnt}, 256'd0);
        exp_commit(r9);
        vword(1'b1);
        idle(2);
        chk("t6_seq", {248'd0, out_rpt_seq}, 256'd12);

        // 7: saturate the error counter with stray mid flits in IDLE
        n = 65535 - int'(m_ecnt) + 3;
        for (int i = 0; i < n; i++) begin
            exp_err();
            put(2'b11, 4'd0, 128'd0, 1'b1, 1'b0, 1'b0);
        end
        idle(3);
        chk("t7_err_cnt_sat", {240'd0, out_err_cnt}, {240'd0, 16'hFFFF});
        chk("t7_outputs_kept", {248'd0, out_rpt_seq}, 256'd12);

        idle(3);
        chk("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
